// File: rtl/spi_slave_word_unit.sv
// spi_slave_word_unit
// SPI slave word engine. SCLK, CS and MOSI are oversampled on i_clk
// through SYNC_STAGES-deep synchronisers. All four CPOL/CPHA modes are
// supported. WIDTH-bit words are shifted MSB- or LSB-first. A one-entry
// transmit buffer uses a valid/ready handshake, and a strobe marks each
// received word.
//
// Build option: define SPI_EXE_ECHO_EN so that a word load that finds the
// transmit buffer empty sends the last received word (o_rx_data) instead
// of all zeros. o_underrun pulses in both builds.
module spi_slave_word_unit #(
   parameter int WIDTH       = 8,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter bit MSB_FIRST   = 1'b1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_sclk,
   input  logic             i_cs,
   input  logic             i_mosi,
   output logic             o_miso,
   output logic             o_miso_oe,
   input  logic [WIDTH-1:0] i_tx_data,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
   output logic             o_underrun,
   output logic             o_busy
);

   localparam int CW = $clog2(WIDTH);
   localparam int FW = $clog2(SYNC_STAGES + 1) + 1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                 state;

   // synchroniser chains, oldest sample at the top index
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_prev;
   logic                   sclk_s;
   logic                   cs_s;
   logic                   mosi_s;

   // after reset the chains hold idle levels, not the pins; 'filled'
   // marks the point where the synchronised CS reflects the real pin
   logic [FW-1:0]          fill_cnt;
   logic                   filled;
   logic                   armed;

   logic [CW-1:0]          bit_cnt;
   logic                   first_pend;
   logic [WIDTH-1:0]       tx_sh;
   logic [WIDTH-1:0]       rx_sh;
   logic [WIDTH-1:0]       tx_buf;
   logic                   tx_ready;
   logic [WIDTH-1:0]       rx_word;
   logic                   rx_valid;
   logic                   underrun;
   logic                   miso;

   logic                   lead_edge;
   logic                   trail_edge;
   logic                   sample_edge;
   logic                   shift_edge;
   logic                   start;
   logic                   stop;
   logic                   act;
   logic                   do_sample;
   logic                   do_shift;
   logic                   last_bit;
   logic                   reload;
   logic                   load;
   logic                   accept;
   logic [WIDTH-1:0]       dflt_word;
   logic [WIDTH-1:0]       load_word;

   // next transmit shifter value after one bit has been sent
   function automatic logic [WIDTH-1:0] tx_advance(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return {w[WIDTH-2:0], 1'b0};
      else           return {1'b0, w[WIDTH-1:1]};
   endfunction

   // bit currently presented on MISO for a given shifter value
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      if (MSB_FIRST) return w[WIDTH-1];
      else           return w[0];
   endfunction

   // receive shifter with one new bit inserted in transfer order
   function automatic logic [WIDTH-1:0] rx_insert(input logic [WIDTH-1:0] w,
                                                  input logic b);
      if (MSB_FIRST) return {w[WIDTH-2:0], b};
      else           return {b, w[WIDTH-1:1]};
   endfunction

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign filled = (fill_cnt == FW'(SYNC_STAGES));

   // leading edge leaves the idle level, trailing edge returns to it
   assign lead_edge   = (sclk_prev == CPOL) && (sclk_s != CPOL);
   assign trail_edge  = (sclk_prev != CPOL) && (sclk_s == CPOL);
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge  : trail_edge;

   // a rising CS takes priority over any SCLK edge in the same cycle
   assign start     = (state == IDLE) && armed && !cs_s;
   assign stop      = (state == ACTIVE) && cs_s;
   assign act       = (state == ACTIVE) && !cs_s;
   assign do_sample = act && sample_edge;
   assign do_shift  = act && shift_edge;
   assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

   // next-word reload: at word completion for CPHA=0, at the first
   // leading edge of a following word for CPHA=1
   assign reload = CPHA ? (do_shift && (bit_cnt == '0) && !first_pend)
                        : (do_sample && last_bit);
   assign load   = start || reload;
   assign accept = i_tx_valid && tx_ready;

`ifdef SPI_EXE_ECHO_EN
   assign dflt_word = rx_word;
`else
   assign dflt_word = '0;
`endif

   // an empty buffer supplies the default word; an accept in the same
   // cycle is not bypassed into the shifter
   assign load_word = tx_ready ? dflt_word : tx_buf;

   assign o_miso     = miso;
   assign o_miso_oe  = ~cs_s;
   assign o_tx_ready = tx_ready;
   assign o_rx_data  = rx_word;
   assign o_rx_valid = rx_valid;
   assign o_underrun = underrun;
   assign o_busy     = (state == ACTIVE);

   // pin synchronisers and the delayed SCLK copy used for edge detection
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sclk_sync <= {SYNC_STAGES{CPOL}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= CPOL;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
         sclk_prev <= sclk_s;
      end
   end

   // data-only registers: transmit buffer contents and receive shifter
   always_ff @(posedge i_clk) begin
      if (accept)    tx_buf <= i_tx_data;
      if (do_sample) rx_sh  <= rx_insert(rx_sh, mosi_s);
   end

   // frame state machine, bit counter, transmit shifter and strobes
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         fill_cnt   <= '0;
         armed      <= 1'b0;
         bit_cnt    <= '0;
         first_pend <= 1'b0;
         tx_sh      <= '0;
         miso       <= 1'b0;
         tx_ready   <= 1'b1;
         rx_word    <= '0;
         rx_valid   <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;

         if (!filled) fill_cnt <= fill_cnt + 1'b1;

         // buffer occupancy: accept fills it, a load of a full buffer empties it
         if (load && tx_ready) underrun <= 1'b1;
         if (accept)           tx_ready <= 1'b0;
         else if (load)        tx_ready <= 1'b1;

         case (state)
            IDLE: begin
               bit_cnt    <= '0;
               miso       <= 1'b0;
               first_pend <= 1'b0;
               if (filled && cs_s) armed <= 1'b1;
               if (start) begin
                  state      <= ACTIVE;
                  tx_sh      <= load_word;
                  first_pend <= 1'b1;
                  if (!CPHA) miso <= out_bit(load_word);
               end else begin
                  tx_sh <= '0;
               end
            end

            ACTIVE: begin
               if (stop) begin
                  state      <= IDLE;
                  bit_cnt    <= '0;
                  tx_sh      <= '0;
                  miso       <= 1'b0;
                  first_pend <= 1'b0;
               end else begin
                  if (do_sample) begin
                     if (last_bit) begin
                        bit_cnt  <= '0;
                        rx_word  <= rx_insert(rx_sh, mosi_s);
                        rx_valid <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  if (reload) begin
                     tx_sh <= load_word;
                     miso  <= out_bit(load_word);
                  end else if (do_shift && CPHA && first_pend) begin
                     // first CPHA=1 shift edge presents bit 0 without shifting
                     miso       <= out_bit(tx_sh);
                     first_pend <= 1'b0;
                  end else if (do_shift && (bit_cnt != '0)) begin
                     tx_sh <= tx_advance(tx_sh);
                     miso  <= out_bit(tx_advance(tx_sh));
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
